// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the architectural zero register and the wait-counter sizing helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bits needed to count from 0 up to and including the timeout value.
    function automatic int wait_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_loaduse_detect.sv
// Combinational load-use detector: flags when the load in EX writes a
// register that the instruction in ID is about to read.
module loaduse_detect
    import hazard_pkg::*;
(
    input  logic       ex_mem_rd,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    // Writes to $zero never produce a real dependency.
    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_use_rt && (ex_rt == id_rt);
        load_use = ex_mem_rd && (ex_rt != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use hazards, taken
// branches/jumps in ID and multi-cycle data-memory accesses (with a
// watchdog), and counts stall cycles for performance measurement.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_Rs_i,
    input  logic [4:0]       ID_Rt_i,
    input  logic             ID_UseRt_i,
    input  logic             ID_BranchTaken_i,
    input  logic             ID_Jump_i,
    input  logic             EX_MemRd_i,
    input  logic [4:0]       EX_Rt_i,
    input  logic             MEM_MemRd_i,
    input  logic             MEM_MemWr_i,
    input  logic             dmem_ack_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             ID_EX_Hold_o,
    output logic             EX_MEM_Hold_o,
    output logic             MEM_WB_Bubble_o,
    output logic             dmem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int               WAIT_W    = wait_cnt_w(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem;
    logic              lu;
    logic              redirect;

    loaduse_detect u_loaduse_detect (
        .ex_mem_rd (EX_MemRd_i),
        .ex_rt     (EX_Rt_i),
        .id_rs     (ID_Rs_i),
        .id_rt     (ID_Rt_i),
        .id_use_rt (ID_UseRt_i),
        .load_use  (lu)
    );

    assign mem      = MEM_MemRd_i | MEM_MemWr_i;
    assign redirect = ID_BranchTaken_i | ID_Jump_i;

    // Mealy pipeline controls; reset forces a safe drained pipeline regardless of state.
    always_comb begin
        PC_Write_o      = 1'b1;
        IF_ID_Write_o   = 1'b1;
        IF_ID_Flush_o   = 1'b0;
        ID_EX_Bubble_o  = 1'b0;
        ID_EX_Hold_o    = 1'b0;
        EX_MEM_Hold_o   = 1'b0;
        MEM_WB_Bubble_o = 1'b0;
        dmem_req_o      = 1'b0;
        err_o           = 1'b0;
        if (rst_i) begin
            PC_Write_o      = 1'b0;
            IF_ID_Write_o   = 1'b0;
            IF_ID_Flush_o   = 1'b1;
            ID_EX_Bubble_o  = 1'b1;
            MEM_WB_Bubble_o = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    dmem_req_o = mem;
                    if (mem && !dmem_ack_i) begin
                        PC_Write_o      = 1'b0;
                        IF_ID_Write_o   = 1'b0;
                        ID_EX_Hold_o    = 1'b1;
                        EX_MEM_Hold_o   = 1'b1;
                        MEM_WB_Bubble_o = 1'b1;
                    end else if (lu) begin
                        // Branch in ID is deferred: it re-resolves once the bubble clears.
                        PC_Write_o     = 1'b0;
                        IF_ID_Write_o  = 1'b0;
                        ID_EX_Bubble_o = 1'b1;
                    end else if (redirect) begin
                        IF_ID_Flush_o = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    dmem_req_o = 1'b1;
                    if (!dmem_ack_i) begin
                        PC_Write_o      = 1'b0;
                        IF_ID_Write_o   = 1'b0;
                        ID_EX_Hold_o    = 1'b1;
                        EX_MEM_Hold_o   = 1'b1;
                        MEM_WB_Bubble_o = 1'b1;
                    end else if (lu) begin
                        PC_Write_o     = 1'b0;
                        IF_ID_Write_o  = 1'b0;
                        ID_EX_Bubble_o = 1'b1;
                    end else if (redirect) begin
                        IF_ID_Flush_o = 1'b1;
                    end
                end
                default: begin
                    // Error: pipeline frozen permanently, request withdrawn.
                    PC_Write_o      = 1'b0;
                    IF_ID_Write_o   = 1'b0;
                    ID_EX_Hold_o    = 1'b1;
                    EX_MEM_Hold_o   = 1'b1;
                    MEM_WB_Bubble_o = 1'b1;
                    err_o           = 1'b1;
                end
            endcase
        end
    end

    // Sequencing FSM with memory-wait watchdog; ack wins over timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem && !dmem_ack_i) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state <= ST_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; error-state cycles are not counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (state != ST_ERROR && !PC_Write_o && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] ID_Rs_i, ID_Rt_i, EX_Rt_i;
    logic       ID_UseRt_i, ID_BranchTaken_i, ID_Jump_i, EX_MemRd_i;
    logic       MEM_MemRd_i, MEM_MemWr_i, dmem_ack_i;
    logic       PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o;
    logic       ID_EX_Hold_o, EX_MEM_Hold_o, MEM_WB_Bubble_o, dmem_req_o, err_o;
    logic [3:0] stall_cnt_o;
    logic [8:0] ctl;

    int total = 0;
    int bad   = 0;

    // Control bundle order: pcw ifw flush bubble idex_hold exmem_hold mwb_bubble req err
    localparam logic [8:0] C_NORMAL  = 9'b110000000;
    localparam logic [8:0] C_RESET   = 9'b001100100;
    localparam logic [8:0] C_LU      = 9'b000100000;
    localparam logic [8:0] C_FLUSH   = 9'b111000000;
    localparam logic [8:0] C_FRZ_REQ = 9'b000011110;
    localparam logic [8:0] C_NRM_REQ = 9'b110000010;
    localparam logic [8:0] C_LU_REQ  = 9'b000100010;
    localparam logic [8:0] C_ERR     = 9'b000011101;

    assign ctl = {PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, ID_EX_Hold_o,
                  EX_MEM_Hold_o, MEM_WB_Bubble_o, dmem_req_o, err_o};

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_Rs_i(ID_Rs_i), .ID_Rt_i(ID_Rt_i), .ID_UseRt_i(ID_UseRt_i),
        .ID_BranchTaken_i(ID_BranchTaken_i), .ID_Jump_i(ID_Jump_i),
        .EX_MemRd_i(EX_MemRd_i), .EX_Rt_i(EX_Rt_i),
        .MEM_MemRd_i(MEM_MemRd_i), .MEM_MemWr_i(MEM_MemWr_i), .dmem_ack_i(dmem_ack_i),
        .PC_Write_o(PC_Write_o), .IF_ID_Write_o(IF_ID_Write_o), .IF_ID_Flush_o(IF_ID_Flush_o),
        .ID_EX_Bubble_o(ID_EX_Bubble_o), .ID_EX_Hold_o(ID_EX_Hold_o),
        .EX_MEM_Hold_o(EX_MEM_Hold_o), .MEM_WB_Bubble_o(MEM_WB_Bubble_o),
        .dmem_req_o(dmem_req_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        ID_Rs_i = 5'd0; ID_Rt_i = 5'd0; EX_Rt_i = 5'd0;
        ID_UseRt_i = 1'b0; ID_BranchTaken_i = 1'b0; ID_Jump_i = 1'b0; EX_MemRd_i = 1'b0;
        MEM_MemRd_i = 1'b0; MEM_MemWr_i = 1'b0; dmem_ack_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        #2;
        total++;
        if (ctl !== C_RESET) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); end
        total++;
        if (stall_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o); end
        step();
        rst_i = 1'b0;
        #1;
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        EX_MemRd_i = 1'b1; EX_Rt_i = 5'd8; ID_Rs_i = 5'd8;
        #1;
        total++;
        if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, C_LU); end
        step();
        idle();
        #1;
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, C_NORMAL); end
        total++;
        if (stall_cnt_o !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt_o); end
        // Load into $zero is never a hazard
        EX_MemRd_i = 1'b1; EX_Rt_i = 5'd0; ID_Rs_i = 5'd0;
        #1;
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL lu_zero_ctl got=%b exp=%b", ctl, C_NORMAL); end
        step();
        total++;
        if (stall_cnt_o !== 4'd1) begin bad++; $display("FAIL lu_zero_cnt got=%0d exp=1", stall_cnt_o); end
        // Rt dependency only counts when ID actually reads Rt
        EX_MemRd_i = 1'b1; EX_Rt_i = 5'd9; ID_Rs_i = 5'd3; ID_Rt_i = 5'd9; ID_UseRt_i = 1'b0;
        #1;
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL lu_rt_unused got=%b exp=%b", ctl, C_NORMAL); end
        ID_UseRt_i = 1'b1;
        #1;
        total++;
        if (ctl !== C_LU) begin bad++; $display("FAIL lu_rt_used got=%b exp=%b", ctl, C_LU); end
        step();
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        ID_BranchTaken_i = 1'b1;
        #1;
        total++;
        if (ctl !== C_FLUSH) begin bad++; $display("FAIL br_flush got=%b exp=%b", ctl, C_FLUSH); end
        step();
        idle();
        #1;
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL br_one_cycle got=%b exp=%b", ctl, C_NORMAL); end
        ID_Jump_i = 1'b1;
        #1;
        total++;
        if (ctl !== C_FLUSH) begin bad++; $display("FAIL jump_flush got=%b exp=%b", ctl, C_FLUSH); end
        step();
        idle();
        // Branch with load-use: bubble first, flush next cycle
        ID_BranchTaken_i = 1'b1; EX_MemRd_i = 1'b1; EX_Rt_i = 5'd4; ID_Rs_i = 5'd4;
        #1;
        total++;
        if (ctl !== C_LU) begin bad++; $display("FAIL br_lu_bubble got=%b exp=%b", ctl, C_LU); end
        step();
        EX_MemRd_i = 1'b0;
        #1;
        total++;
        if (ctl !== C_FLUSH) begin bad++; $display("FAIL br_lu_flush got=%b exp=%b", ctl, C_FLUSH); end
        step();
        idle();
    endtask

    task automatic test_mem_wait();
        int req_cycles;
        int frz_cycles;
        logic [8:0] exp;
        do_reset();
        // Zero-wait access adds no stall
        MEM_MemRd_i = 1'b1; dmem_ack_i = 1'b1;
        #1;
        total++;
        if (ctl !== C_NRM_REQ) begin bad++; $display("FAIL zero_wait_ctl got=%b exp=%b", ctl, C_NRM_REQ); end
        step();
        total++;
        if (stall_cnt_o !== 4'd0) begin bad++; $display("FAIL zero_wait_cnt got=%0d exp=0", stall_cnt_o); end
        idle();
        // Store acked 3 cycles after first request
        req_cycles = 0;
        frz_cycles = 0;
        MEM_MemWr_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_ack_i = (i == 3);
            exp = (i == 3) ? C_NRM_REQ : C_FRZ_REQ;
            #1;
            total++;
            if (ctl !== exp) begin bad++; $display("FAIL store_wait_c%0d got=%b exp=%b", i, ctl, exp); end
            if (dmem_req_o) req_cycles++;
            if (!PC_Write_o) frz_cycles++;
            step();
        end
        idle();
        #1;
        total++;
        if (req_cycles != 4 || frz_cycles != 3) begin
            bad++; $display("FAIL store_counts got=req%0d/frz%0d exp=req4/frz3", req_cycles, frz_cycles);
        end
        total++;
        if (stall_cnt_o !== 4'd3) begin bad++; $display("FAIL store_cnt got=%0d exp=3", stall_cnt_o); end
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL store_release got=%b exp=%b", ctl, C_NORMAL); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        // mem + lu + branch: freeze wins
        MEM_MemRd_i = 1'b1; EX_MemRd_i = 1'b1; EX_Rt_i = 5'd5; ID_Rs_i = 5'd5; ID_BranchTaken_i = 1'b1;
        #1;
        total++;
        if (ctl !== C_FRZ_REQ) begin bad++; $display("FAIL all_three got=%b exp=%b", ctl, C_FRZ_REQ); end
        step();
        // ack + lu in MEM_WAIT: release with bubble in the same cycle
        dmem_ack_i = 1'b1;
        #1;
        total++;
        if (ctl !== C_LU_REQ) begin bad++; $display("FAIL ack_lu got=%b exp=%b", ctl, C_LU_REQ); end
        step();
        MEM_MemRd_i = 1'b0; dmem_ack_i = 1'b0; EX_MemRd_i = 1'b0;
        #1;
        total++;
        if (ctl !== C_FLUSH) begin bad++; $display("FAIL release_flush got=%b exp=%b", ctl, C_FLUSH); end
        step();
        idle();
    endtask

    task automatic test_timeout();
        logic [8:0] exp;
        do_reset();
        MEM_MemRd_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin dmem_ack_i = 1'b1; MEM_MemRd_i = 1'b0; end
            exp = (i < 5) ? C_FRZ_REQ : C_ERR;
            #1;
            total++;
            if (ctl !== exp) begin bad++; $display("FAIL timeout_c%0d got=%b exp=%b", i, ctl, exp); end
            step();
        end
        total++;
        if (stall_cnt_o !== 4'd5) begin bad++; $display("FAIL timeout_cnt got=%0d exp=5", stall_cnt_o); end
        do_reset();
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL err_cleared got=%b exp=%b", ctl, C_NORMAL); end
        // Ack in the last allowed cycle is accepted
        MEM_MemRd_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dmem_ack_i = (i == 4);
            exp = (i == 4) ? C_NRM_REQ : C_FRZ_REQ;
            #1;
            total++;
            if (ctl !== exp) begin bad++; $display("FAIL late_ack_c%0d got=%b exp=%b", i, ctl, exp); end
            step();
        end
        idle();
        #1;
        total++;
        if (ctl !== C_NORMAL) begin bad++; $display("FAIL late_ack_run got=%b exp=%b", ctl, C_NORMAL); end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        MEM_MemWr_i = 1'b1;
        step();
        step();
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if (ctl !== C_RESET) begin bad++; $display("FAIL midwait_rst_ctl got=%b exp=%b", ctl, C_RESET); end
        total++;
        if (stall_cnt_o !== 4'd0) begin bad++; $display("FAIL midwait_rst_cnt got=%0d exp=0", stall_cnt_o); end
        idle();
        step();
        rst_i = 1'b0;
        #1;
        total++;
        if (ctl !== C_NORMAL || stall_cnt_o !== 4'd0) begin
            bad++; $display("FAIL midwait_release got=%b/%0d exp=%b/0", ctl, stall_cnt_o, C_NORMAL);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_cnt;
        do_reset();
        EX_MemRd_i = 1'b1; EX_Rt_i = 5'd12; ID_Rs_i = 5'd12;
        for (int i = 0; i < 20; i++) begin
            exp_cnt = (i < 15) ? 4'(i) : 4'd15;
            #1;
            total++;
            if (stall_cnt_o !== exp_cnt) begin bad++; $display("FAIL sat_c%0d got=%0d exp=%0d", i, stall_cnt_o, exp_cnt); end
            step();
        end
        idle();
        #1;
        total++;
        if (stall_cnt_o !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", stall_cnt_o); end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_simultaneous();
        test_timeout();
        test_reset_midwait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the write-enable, flush, hold and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions: load-use hazards, taken branches and jumps resolved in ID, and multi-cycle data-memory accesses through a req/ack handshake with a watchdog. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- TIMEOUT, 255: maximum MEM_WAIT cycles before the block declares a memory error (range 1..1023).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- ID_Rs_i  in  5  Rs field of the instruction in ID.
- ID_Rt_i  in  5  Rt field of the instruction in ID.
- ID_UseRt_i  in  1  the ID instruction reads Rt.
- ID_BranchTaken_i  in  1  branch resolved taken in ID.
- ID_Jump_i  in  1  jump in ID.
- EX_MemRd_i  in  1  the instruction in EX is a load.
- EX_Rt_i  in  5  destination of that load.
- MEM_MemRd_i  in  1  the MEM-stage instruction is a load.
- MEM_MemWr_i  in  1  the MEM-stage instruction is a store.
- dmem_ack_i  in  1  data memory has completed the current access.
- PC_Write_o  out  1  PC update enable.
- IF_ID_Write_o  out  1  IF/ID load enable.
- IF_ID_Flush_o  out  1  load a NOP into IF/ID.
- ID_EX_Bubble_o  out  1  load zero controls into ID/EX.
- ID_EX_Hold_o  out  1  ID/EX keeps its contents.
- EX_MEM_Hold_o  out  1  EX/MEM keeps its contents.
- MEM_WB_Bubble_o  out  1  load zero controls into MEM/WB.
- dmem_req_o  out  1  data-memory request.
- err_o  out  1  memory timeout; sticky until reset.
- stall_cnt_o  out  CNT_W  count of stall cycles.

## Operation
- The FSM has three states: RUN, MEM_WAIT, ERROR. A wait counter (width clog2(TIMEOUT+1)) runs alongside it.
- Signal `mem` = MEM_MemRd_i | MEM_MemWr_i.
- Signal `lu` (load-use) = EX_MemRd_i & EX_Rt_i≠0 & (EX_Rt_i==ID_Rs_i | (ID_UseRt_i & EX_Rt_i==ID_Rt_i)).
- Default outputs: PC_Write_o=1, IF_ID_Write_o=1, all flush/hold/bubble outputs=0, dmem_req_o=0.

RUN state:
- dmem_req_o=mem.
- If mem & !dmem_ack_i: freeze.
  - Freeze means PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Hold_o=1, EX_MEM_Hold_o=1, MEM_WB_Bubble_o=1.
  - The FSM goes to MEM_WAIT and the wait counter is set to 1.
- Else if lu: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1. Any branch or jump in ID is ignored this cycle and re-evaluated next cycle.
- Else if ID_BranchTaken_i | ID_Jump_i: IF_ID_Flush_o=1.

MEM_WAIT state:
- dmem_req_o=1.
- On dmem_ack_i: the pipeline advances normally, with the lu and branch rules applied as in RUN, and the FSM returns to RUN.
- Otherwise the pipeline stays frozen.
  - If wait counter == TIMEOUT, go to ERROR.
  - Otherwise increment the wait counter.
- dmem_ack_i takes priority over the timeout.

ERROR state:
- Frozen, dmem_req_o=0, err_o=1.
- Only rst_i exits this state.

Stall counter:
- stall_cnt_o increments on every RUN or MEM_WAIT cycle with PC_Write_o=0.
- It saturates at 2^CNT_W−1 and never wraps.

Inputs while the block is frozen are don't-care except dmem_ack_i.

## Timing
- Outputs are Mealy, combinational from state and inputs, and valid in the same cycle. Every output has zero latency.
- The load-use bubble lasts exactly 1 cycle per hazard.
- A branch flush lasts 1 cycle.
- Memory access:
  - A zero-wait access (ack in the same cycle as req) adds no stall.
  - Ack arriving k cycles after the first req adds k stall cycles.
  - dmem_req_o is held high, unchanged, until ack.
- Timeout: if no ack arrives, req is high for TIMEOUT+1 cycles and ERROR is entered on the following edge.
  - Ack in the last of those cycles is accepted and the FSM returns to RUN.
- Reset:
  - While rst_i=1: state=RUN, counters=0, PC_Write_o=0, IF_ID_Write_o=0, IF_ID_Flush_o=1, ID_EX_Bubble_o=1, ID_EX_Hold_o=0, EX_MEM_Hold_o=0, MEM_WB_Bubble_o=1, dmem_req_o=0, err_o=0, stall_cnt_o=0.
  - Reset asserted mid-MEM_WAIT aborts the request immediately; no ack is expected afterward.
- Simultaneous events:
  - mem+lu+branch in the same cycle: memory freeze wins; lu and branch are re-evaluated on release.
  - ack+lu: pipeline releases and the bubble is inserted in that same cycle.

## Structure
- Package hazard_pkg holds:
  - state encoding for RUN/MEM_WAIT/ERROR (2-bit),
  - constant REG_ZERO=5'd0,
  - a function computing the wait-counter width from TIMEOUT.
- One sub-module, loaduse_detect, is purely combinational and computes `lu` from the ID/EX register fields.
- The FSM, wait counter and stall counter live in hazard_ctrl.

## Test plan
- Load-use: EX_MemRd_i=1, EX_Rt_i=8, ID_Rs_i=8 → one cycle with PC_Write_o=0, ID_EX_Bubble_o=1, stall_cnt_o 0→1. The same case with EX_Rt_i=0 → no stall.
- Taken branch with no hazard → IF_ID_Flush_o=1 for 1 cycle. Branch plus lu in the same cycle → bubble only, then flush in the following cycle.
- Store with ack 3 cycles after the first req → dmem_req_o high 4 cycles, pipeline frozen 3 cycles, stall_cnt_o=3, pipeline advances on the ack cycle.
- TIMEOUT=4, ack never arrives → req high 5 cycles, then err_o=1 and dmem_req_o=0, held until rst_i. Ack in the 5th req cycle → return to RUN, no error.
- Reset asserted during MEM_WAIT → outputs take reset values asynchronously; after release, RUN with stall_cnt_o=0.
- CNT_W=4 with 20 consecutive lu cycles → stall_cnt_o saturates at 15.
